// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: DEPTH slots with valid/stall/flush, debug step and sticky halt.
// Optional retired-instruction counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_pipe #(
    parameter int NBITS   = 32,
    parameter int RNBITS  = 5,
    parameter int DEPTH   = 1,
    parameter int CNTBITS = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_step,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_valid,
    input  logic [NBITS-1:0]    i_pc4,
    input  logic [NBITS-1:0]    i_pc8,
    input  logic [NBITS-1:0]    i_Instruction,
    input  logic [NBITS-1:0]    i_ALU,
    input  logic [NBITS-1:0]    i_DataMemory,
    input  logic [NBITS-1:0]    i_extension,
    input  logic [RNBITS-1:0]   i_RegistroDestino,
    input  logic                i_JAL,
    input  logic                i_LUI,
    input  logic                i_HALT,
    input  logic                i_MemToReg,
    input  logic                i_RegWrite,
    input  logic                i_ZeroExtend,
    input  logic [1:0]          i_TamanoFiltroL,
    output logic                o_ready,
    output logic                o_valid,
    output logic [NBITS-1:0]    o_pc4,
    output logic [NBITS-1:0]    o_pc8,
    output logic [NBITS-1:0]    o_Instruction,
    output logic [NBITS-1:0]    o_ALU,
    output logic [NBITS-1:0]    o_DatoMemoria,
    output logic [NBITS-1:0]    o_Extension,
    output logic [RNBITS-1:0]   o_RegistroDestino,
    output logic                o_JAL,
    output logic                o_LUI,
    output logic                o_MemToReg,
    output logic                o_RegWrite,
    output logic                o_ZeroExtend,
    output logic [1:0]          o_TamanoFiltroL,
    output logic                o_HALT,
    output logic                o_halted,
    output logic [CNTBITS-1:0]  o_retired
);

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_HALTED = 1'b1;

    typedef struct packed {
        logic [NBITS-1:0]  pc4;
        logic [NBITS-1:0]  pc8;
        logic [NBITS-1:0]  instr;
        logic [NBITS-1:0]  alu;
        logic [NBITS-1:0]  dmem;
        logic [NBITS-1:0]  ext;
        logic [RNBITS-1:0] rd;
        logic              jal;
        logic              lui;
        logic              halt;
        logic              mem_to_reg;
        logic              reg_write;
        logic              zero_ext;
        logic [1:0]        filt;
    } bundle_t;

    logic             state;
    logic             halted;
    logic             adv;
    logic             last_valid;
    logic             halt_hit;
    logic             shift_en;
    bundle_t          in_b;
    bundle_t          last_b;
    bundle_t          slot_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    assign halted     = (state == ST_HALTED);
    assign adv        = i_step & ~i_stall & ~halted;
    assign o_ready    = adv;
    assign last_b     = slot_q[DEPTH-1];
    assign last_valid = valid_q[DEPTH-1];
    assign halt_hit   = last_valid & last_b.halt;
    // A HALT sitting in the last slot retires but does not leave, so the pipe
    // freezes with the HALT bundle still visible.
    assign shift_en   = adv & ~halt_hit;

    always_comb begin
        in_b            = '0;
        in_b.pc4        = i_pc4;
        in_b.pc8        = i_pc8;
        in_b.instr      = i_Instruction;
        in_b.alu        = i_ALU;
        in_b.dmem       = i_DataMemory;
        in_b.ext        = i_extension;
        in_b.rd         = i_RegistroDestino;
        in_b.jal        = i_JAL;
        in_b.lui        = i_LUI;
        in_b.halt       = i_HALT;
        in_b.mem_to_reg = i_MemToReg;
        in_b.reg_write  = i_RegWrite;
        in_b.zero_ext   = i_ZeroExtend;
        in_b.filt       = i_TamanoFiltroL;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            valid_q <= '0;
            state   <= ST_RUN;
        end else begin
            if (shift_en) begin
                slot_q[0]  <= in_b;
                valid_q[0] <= i_valid;
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    slot_q[k]  <= slot_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
            // Flush overrides any simultaneous load; ignored once halted.
            if (i_flush && !halted) begin
                valid_q <= '0;
            end
            if (state == ST_RUN && halt_hit) begin
                state <= ST_HALTED;
            end
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [CNTBITS-1:0] retired_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            retired_q <= '0;
        end else if (adv && last_valid && (retired_q != '1)) begin
            retired_q <= retired_q + CNTBITS'(1);
        end
    end

    assign o_retired = retired_q;
`else
    assign o_retired = '0;
`endif

    assign o_valid           = last_valid;
    assign o_halted          = halted;
    assign o_pc4             = last_b.pc4;
    assign o_pc8             = last_b.pc8;
    assign o_Instruction     = last_b.instr;
    assign o_ALU             = last_b.alu;
    assign o_DatoMemoria     = last_b.dmem;
    assign o_Extension       = last_b.ext;
    assign o_RegistroDestino = last_b.rd;
    assign o_ZeroExtend      = last_b.zero_ext;
    assign o_TamanoFiltroL   = last_b.filt;
    assign o_JAL             = last_valid & last_b.jal;
    assign o_LUI             = last_valid & last_b.lui;
    assign o_HALT            = last_valid & last_b.halt;
    assign o_MemToReg        = last_valid & last_b.mem_to_reg;
    assign o_RegWrite        = last_valid & last_b.reg_write;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe (DEPTH=2, CNTBITS=4).
// Expected retire counts follow MEM_WB_RETIRE_CNT_EN.
module tb_mem_wb_pipe;

`ifdef MEM_WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset, i_step, i_stall, i_flush, i_valid;
    logic [31:0] i_pc4, i_pc8, i_Instruction, i_ALU, i_DataMemory, i_extension;
    logic [4:0]  i_RegistroDestino;
    logic        i_JAL, i_LUI, i_HALT, i_MemToReg, i_RegWrite, i_ZeroExtend;
    logic [1:0]  i_TamanoFiltroL;
    logic        o_ready, o_valid;
    logic [31:0] o_pc4, o_pc8, o_Instruction, o_ALU, o_DatoMemoria, o_Extension;
    logic [4:0]  o_RegistroDestino;
    logic        o_JAL, o_LUI, o_MemToReg, o_RegWrite, o_ZeroExtend, o_HALT, o_halted;
    logic [1:0]  o_TamanoFiltroL;
    logic [3:0]  o_retired;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_pipe #(.NBITS(32), .RNBITS(5), .DEPTH(2), .CNTBITS(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_stall(i_stall),
        .i_flush(i_flush), .i_valid(i_valid), .i_pc4(i_pc4), .i_pc8(i_pc8),
        .i_Instruction(i_Instruction), .i_ALU(i_ALU), .i_DataMemory(i_DataMemory),
        .i_extension(i_extension), .i_RegistroDestino(i_RegistroDestino),
        .i_JAL(i_JAL), .i_LUI(i_LUI), .i_HALT(i_HALT), .i_MemToReg(i_MemToReg),
        .i_RegWrite(i_RegWrite), .i_ZeroExtend(i_ZeroExtend),
        .i_TamanoFiltroL(i_TamanoFiltroL), .o_ready(o_ready), .o_valid(o_valid),
        .o_pc4(o_pc4), .o_pc8(o_pc8), .o_Instruction(o_Instruction), .o_ALU(o_ALU),
        .o_DatoMemoria(o_DatoMemoria), .o_Extension(o_Extension),
        .o_RegistroDestino(o_RegistroDestino), .o_JAL(o_JAL), .o_LUI(o_LUI),
        .o_MemToReg(o_MemToReg), .o_RegWrite(o_RegWrite), .o_ZeroExtend(o_ZeroExtend),
        .o_TamanoFiltroL(o_TamanoFiltroL), .o_HALT(o_HALT), .o_halted(o_halted),
        .o_retired(o_retired)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [3:0] exp_ret(input int n);
        return CNT_EN ? 4'(n) : 4'd0;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic [31:0] alu);
        i_ALU             = alu;
        i_DataMemory      = alu + 32'h100;
        i_RegistroDestino = alu[4:0];
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        #2;
        i_reset = 1'b0;
    endtask

    task automatic idle_inputs();
        i_reset = 1'b0; i_step = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        i_pc4 = 32'h4; i_pc8 = 32'h8; i_Instruction = 32'hDEAD_BEEF; i_extension = 32'hFFFF_0001;
        load(32'h0);
        i_JAL = 1'b0; i_LUI = 1'b0; i_HALT = 1'b0; i_MemToReg = 1'b0; i_RegWrite = 1'b0;
        i_ZeroExtend = 1'b0; i_TamanoFiltroL = 2'b00;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_reset = 1'b1;
        #12;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        n_tests++; if (o_ALU !== 32'h0) begin n_fail++; $display("FAIL reset_alu got %h exp 0", o_ALU); end
        n_tests++; if (o_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h exp 0", o_pc4); end
        n_tests++; if (o_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", o_halted); end
        n_tests++; if (o_retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired got %0d exp 0", o_retired); end
        i_reset = 1'b0;
        tick();
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    endtask

    task automatic test_flow();
        do_reset();
        i_valid = 1'b1; i_RegWrite = 1'b1; load(32'h11);
        tick();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flow_e1_valid got %b exp 0", o_valid); end
        load(32'h22);
        tick();
        n_tests++; if (o_ALU !== 32'h11 || o_valid !== 1'b1) begin n_fail++; $display("FAIL flow_e2 got %h/%b exp 11/1", o_ALU, o_valid); end
        n_tests++; if (o_DatoMemoria !== 32'h111 || o_RegistroDestino !== 5'h11) begin n_fail++; $display("FAIL flow_e2_fields got %h/%h exp 111/11", o_DatoMemoria, o_RegistroDestino); end
        n_tests++; if (o_RegWrite !== 1'b1) begin n_fail++; $display("FAIL flow_e2_regwrite got %b exp 1", o_RegWrite); end
        n_tests++; if (o_retired !== exp_ret(0)) begin n_fail++; $display("FAIL flow_e2_ret got %0d exp %0d", o_retired, exp_ret(0)); end
        load(32'h33);
        tick();
        n_tests++; if (o_ALU !== 32'h22) begin n_fail++; $display("FAIL flow_e3 got %h exp 22", o_ALU); end
        n_tests++; if (o_retired !== exp_ret(1)) begin n_fail++; $display("FAIL flow_e3_ret got %0d exp %0d", o_retired, exp_ret(1)); end
        i_valid = 1'b0;
        tick();
        n_tests++; if (o_ALU !== 32'h33 || o_valid !== 1'b1) begin n_fail++; $display("FAIL flow_e4 got %h/%b exp 33/1", o_ALU, o_valid); end
        n_tests++; if (o_retired !== exp_ret(2)) begin n_fail++; $display("FAIL flow_e4_ret got %0d exp %0d", o_retired, exp_ret(2)); end
        tick();
        n_tests++; if (o_valid !== 1'b0 || o_RegWrite !== 1'b0) begin n_fail++; $display("FAIL flow_gate got %b/%b exp 0/0", o_valid, o_RegWrite); end
        n_tests++; if (o_retired !== exp_ret(3)) begin n_fail++; $display("FAIL flow_e5_ret got %0d exp %0d", o_retired, exp_ret(3)); end
        i_RegWrite = 1'b0;
    endtask

    task automatic test_step();
        do_reset();
        i_valid = 1'b1; load(32'hA0); i_step = 1'b0;
        #1;
        n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL step_ready got %b exp 0", o_ready); end
        tick(); tick();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL step_hold got %b exp 0", o_valid); end
        i_step = 1'b1;
        tick(); i_valid = 1'b0; tick();
        n_tests++; if (o_ALU !== 32'hA0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL step_adv got %h/%b exp a0/1", o_ALU, o_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        i_valid = 1'b1; load(32'hA1);
        tick(); load(32'hA2);
        tick(); load(32'hA3);
        i_stall = 1'b1;
        #1;
        n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b exp 0", o_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (o_ALU !== 32'hA1 || o_retired !== exp_ret(0)) begin n_fail++; $display("FAIL stall_hold%0d got %h/%0d exp a1/%0d", i, o_ALU, o_retired, exp_ret(0)); end
        end
        i_stall = 1'b0;
        tick();
        n_tests++; if (o_ALU !== 32'hA2 || o_retired !== exp_ret(1)) begin n_fail++; $display("FAIL stall_resume1 got %h/%0d exp a2/%0d", o_ALU, o_retired, exp_ret(1)); end
        load(32'hA4);
        tick();
        n_tests++; if (o_ALU !== 32'hA3 || o_retired !== exp_ret(2)) begin n_fail++; $display("FAIL stall_resume2 got %h/%0d exp a3/%0d", o_ALU, o_retired, exp_ret(2)); end
        i_valid = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        i_valid = 1'b1; i_RegWrite = 1'b1; load(32'h55);
        tick();
        load(32'h66); i_flush = 1'b1;
        tick();
        i_flush = 1'b0; load(32'h77);
        n_tests++; if (o_valid !== 1'b0 || o_RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_now got %b/%b exp 0/0", o_valid, o_RegWrite); end
        tick();
        n_tests++; if (o_valid !== 1'b0 || o_RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_load_dropped got %b/%b exp 0/0", o_valid, o_RegWrite); end
        n_tests++; if (o_retired !== 4'd0) begin n_fail++; $display("FAIL flush_ret got %0d exp 0", o_retired); end
        i_valid = 1'b0;
        tick();
        n_tests++; if (o_ALU !== 32'h77 || o_valid !== 1'b1) begin n_fail++; $display("FAIL flush_after got %h/%b exp 77/1", o_ALU, o_valid); end
        i_RegWrite = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        i_valid = 1'b1; i_HALT = 1'b1; i_RegWrite = 1'b1; load(32'h1);
        tick();
        i_HALT = 1'b0; load(32'h2);
        tick();
        load(32'h3);
        n_tests++; if (o_HALT !== 1'b1 || o_halted !== 1'b0) begin n_fail++; $display("FAIL halt_arrive got %b/%b exp 1/0", o_HALT, o_halted); end
        tick();
        n_tests++; if (o_halted !== 1'b1 || o_ready !== 1'b0) begin n_fail++; $display("FAIL halt_state got %b/%b exp 1/0", o_halted, o_ready); end
        n_tests++; if (o_retired !== exp_ret(1)) begin n_fail++; $display("FAIL halt_ret got %0d exp %0d", o_retired, exp_ret(1)); end
        n_tests++; if (o_ALU !== 32'h1 || o_HALT !== 1'b1) begin n_fail++; $display("FAIL halt_frozen got %h/%b exp 1/1", o_ALU, o_HALT); end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick(); tick();
        n_tests++; if (o_valid !== 1'b1 || o_ALU !== 32'h1 || o_halted !== 1'b1) begin n_fail++; $display("FAIL halt_flush_ign got %b/%h/%b exp 1/1/1", o_valid, o_ALU, o_halted); end
        n_tests++; if (o_retired !== exp_ret(1)) begin n_fail++; $display("FAIL halt_ret_hold got %0d exp %0d", o_retired, exp_ret(1)); end
        i_reset = 1'b1;
        #2;
        n_tests++; if (o_halted !== 1'b0 || o_valid !== 1'b0 || o_HALT !== 1'b0 || o_ALU !== 32'h0 || o_RegWrite !== 1'b0) begin n_fail++; $display("FAIL halt_reset got %b/%b/%b/%h/%b exp 0/0/0/0/0", o_halted, o_valid, o_HALT, o_ALU, o_RegWrite); end
        n_tests++; if (o_retired !== 4'd0) begin n_fail++; $display("FAIL halt_reset_ret got %0d exp 0", o_retired); end
        i_reset = 1'b0; i_valid = 1'b0; i_RegWrite = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        i_valid = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        n_tests++; if (o_retired !== exp_ret(14)) begin n_fail++; $display("FAIL sat_14 got %0d exp %0d", o_retired, exp_ret(14)); end
        tick();
        n_tests++; if (o_retired !== exp_ret(15)) begin n_fail++; $display("FAIL sat_15 got %0d exp %0d", o_retired, exp_ret(15)); end
        for (int i = 0; i < 5; i++) tick();
        n_tests++; if (o_retired !== exp_ret(15)) begin n_fail++; $display("FAIL sat_hold got %0d exp %0d", o_retired, exp_ret(15)); end
        i_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_flow();
        test_step();
        test_stall();
        test_flush();
        test_halt();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline register: carries the memory-stage result bundle into write-back through `DEPTH` register slots. Compared with a plain stage latch, it adds:
- per-slot valid bits with stall and flush;
- debug single-step gating;
- a sticky halt state that freezes the pipe;
- an optional retired-instruction counter.

It sits between the data-memory stage and the write-back mux/register file.

## Interface
Parameters:
- `NBITS`, 32, datapath width.
- `RNBITS`, 5, register-index width.
- `DEPTH`, 1, number of register slots, legal 1..4.
- `CNTBITS`, 16, retire-counter width.

Ports:
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_step`  in  1  debug advance enable; 0 holds every slot.
- `i_stall`  in  1  hold request from hazard unit.
- `i_flush`  in  1  invalidate every slot.
- `i_valid`  in  1  input bundle carries a real instruction.
- `i_pc4`, `i_pc8`, `i_Instruction`, `i_ALU`, `i_DataMemory`, `i_extension`  in  NBITS each  data bundle.
- `i_RegistroDestino`  in  RNBITS  destination register.
- `i_JAL`, `i_LUI`, `i_HALT`, `i_MemToReg`, `i_RegWrite`, `i_ZeroExtend`  in  1 each  WB controls.
- `i_TamanoFiltroL`  in  2  load-size filter.
- `o_ready`  out  1  pipe will accept the input bundle this cycle.
- `o_valid`  out  1  last slot holds a valid instruction.
- `o_pc4`…`o_ZeroExtend`, `o_TamanoFiltroL`, `o_HALT`  out  same widths as inputs  last-slot contents (`o_DatoMemoria` for `i_DataMemory`, `o_Extension` for `i_extension`).
- `o_halted`  out  1  sticky halt state.
- `o_retired`  out  CNTBITS  count of retired valid instructions.

## Operation
- Define `adv = i_step & ~i_stall & ~halted`.
- When `adv=1`:
  - slot0 loads the input bundle and `i_valid`;
  - slot k loads slot k-1;
  - the last slot retires.
- When `adv=0`: every slot holds.
- `o_ready = adv`.
- Flush:
  - `i_flush=1` clears all valid bits on the edge, independent of `adv` and `i_step`.
  - Flush wins over a simultaneous load: slot0 valid=0 even when `i_valid=1`.
  - Data fields may load or hold; they are don't-care.
- Control gating: `o_RegWrite`, `o_MemToReg`, `o_JAL`, `o_LUI` and `o_HALT` are forced to 0 whenever the last slot is invalid. Data outputs are not gated.
- FSM states:
  - **RUN** (reset state): normal operation.
  - **HALTED**: entered on the edge after the last slot holds valid & HALT, while in RUN. `o_halted=1`, `adv` forced 0, and flush is ignored. Only `i_reset` exits.
- Retire counter:
  - increments on each edge with `adv=1` and a valid last slot, including the HALT instruction itself;
  - saturates at 2^CNTBITS-1 (no wrap).

## Timing
- Reset (asynchronous, immediate): all slots zero and invalid, `o_valid=0`, all data and control outputs 0, `o_halted=0`, `o_retired=0`, FSM=RUN.
- Reset asserted mid-operation discards in-flight slots immediately, without waiting for a clock edge.
- Latency: a bundle accepted on edge N is visible at the outputs after edge N+DEPTH-1, counting only edges with `adv=1`.
- `o_ready` is combinational from `i_step`, `i_stall` and the halt state. No other combinational input-to-output paths exist.
- HALT on the output in cycle C gives `o_halted=1` from edge C+1; `o_retired` counts the HALT at that same edge.
- The last slot freezes showing the HALT bundle.

## Configuration
- `MEM_WB_RETIRE_CNT_EN` defined: counter implemented as described.
- `MEM_WB_RETIRE_CNT_EN` undefined: no counter flops; `o_retired` is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset and flow, DEPTH=2: reset; stream `i_ALU` 0x11, 0x22, 0x33 with `i_valid=1`, `i_step=1` -> 0x11 appears on `o_ALU` after the 2nd edge, then 0x22, then 0x33; `o_retired` counts 1, 2, 3.
- Stall: hold `i_stall=1` for 3 cycles mid-stream -> outputs frozen, `o_ready=0`, `o_retired` unchanged; the stream resumes intact.
- Flush with a simultaneous valid load and `i_RegWrite=1` -> next cycle `o_valid=0`, `o_RegWrite=0`, no retire counted.
- Halt: feed HALT followed by two more instructions -> `o_halted=1` one edge after HALT reaches the output; later bundles never appear; `i_flush` is ignored; `o_retired` includes the HALT. Assert `i_reset` -> all outputs 0.
- Counter saturation, CNTBITS=4: retire 20 valid instructions -> `o_retired=15`.
- Build without `MEM_WB_RETIRE_CNT_EN`: repeat the flow test -> `o_retired=0` throughout; all other responses identical.
